nibble_packer: RTL and testbench



---
 rtl/nibble_packer_pkg.sv | 12 +
 rtl/nibble_wr_dec.sv | 15 +
 rtl/nibble_packer.sv | 91 +++++++++
 tb/tb_nibble_packer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/nibble_packer_pkg.sv
// rtl/nibble_packer_pkg.sv - shared constants, state enum and word type for the display digit path
package nibble_packer_pkg;

  localparam int DIGIT_W = 4;
  localparam int DIGITS  = 8;
  localparam int NUM_W   = 3;

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_e;

  typedef logic [DIGITS*DIGIT_W-1:0] disp_word_t;

endpackage

// File: rtl/nibble_wr_dec.sv
// rtl/nibble_wr_dec.sv - 3-to-8 one-hot nibble write-enable decoder gated by the accept strobe
module nibble_wr_dec
  import nibble_packer_pkg::*;
(
  input  logic [NUM_W-1:0]  num,
  input  logic              en,
  output logic [DIGITS-1:0] we
);

  always_comb begin
    we = '0;
    if (en) we[num] = 1'b1;
  end

endmodule

// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - packs 4-bit digits into a 32-bit display word, offers it when full
// Optional backspace input enabled by NIBBLE_PACKER_BACKSPACE_EN.
module nibble_packer #(
  parameter int DIGITS  = 8,
  parameter int DIGIT_W = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [DIGIT_W-1:0]                    in_digit,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  clear,
`ifdef NIBBLE_PACKER_BACKSPACE_EN
  input  logic                                  bksp,
`endif
  output logic [DIGITS*DIGIT_W-1:0]             DATA,
  output logic [nibble_packer_pkg::NUM_W-1:0]   NUM,
  output logic                                  out_valid,
  input  logic                                  out_ready
);

  import nibble_packer_pkg::*;

  state_e           state_q, state_d;
  disp_word_t       data_q, data_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [DIGITS-1:0] we;
  logic             accept, consume;

  assign accept  = (state_q == FILL) && in_valid;
  assign consume = (state_q == FULL) && out_ready;

  nibble_wr_dec u_wr_dec (
    .num (num_q),
    .en  (accept),
    .we  (we)
  );

`ifdef NIBBLE_PACKER_BACKSPACE_EN
  logic [NUM_W-1:0] num_dec;
  assign num_dec = num_q - NUM_W'(1);
`endif

  // Priority: clear, then accept, then consume, then backspace.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    num_d   = num_q;
    if (clear) begin
      state_d = FILL;
      data_d  = '0;
      num_d   = '0;
    end else if (accept) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (we[k]) data_d[k*DIGIT_W +: DIGIT_W] = in_digit;
      end
      num_d = num_q + NUM_W'(1);
      if (num_q == NUM_W'(DIGITS-1)) state_d = FULL;
    end else if (consume) begin
      state_d = FILL;
      data_d  = '0;
      num_d   = '0;
    end
`ifdef NIBBLE_PACKER_BACKSPACE_EN
    else if (bksp && (state_q == FILL) && (num_q != '0)) begin
      num_d = num_dec;
      for (int k = 0; k < DIGITS; k++) begin
        if (num_dec == NUM_W'(k)) data_d[k*DIGIT_W +: DIGIT_W] = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      data_q  <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      num_q   <= num_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == FULL);
  assign DATA      = data_q;
  assign NUM       = num_q;

endmodule

// File: tb/tb_nibble_packer.sv
// tb/tb_nibble_packer.sv - directed self-checking bench for nibble_packer
module tb_nibble_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_digit;
  logic        in_valid;
  logic        in_ready;
  logic        clear;
  logic [31:0] DATA;
  logic [2:0]  NUM;
  logic        out_valid;
  logic        out_ready;
`ifdef NIBBLE_PACKER_BACKSPACE_EN
  logic        bksp;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nibble_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_digit  (in_digit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clear     (clear),
`ifdef NIBBLE_PACKER_BACKSPACE_EN
    .bksp      (bksp),
`endif
    .DATA      (DATA),
    .NUM       (NUM),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] d);
    in_valid = 1'b1;
    in_digit = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_data"},  DATA, 32'h0);
    check({tag, "_num"},   {29'd0, NUM}, 32'd0);
    check({tag, "_rdy"},   {31'd0, in_ready}, 32'd1);
    check({tag, "_ovld"},  {31'd0, out_valid}, 32'd0);
  endtask

  logic [31:0] words [2];
  int          nwords, bubbles, cycles, idx;
  logic        rdy;

  initial begin
    rst_n = 1'b0; in_digit = '0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
`ifdef NIBBLE_PACKER_BACKSPACE_EN
    bksp = 1'b0;
`endif
    step(); step();
    rst_n = 1'b1;
    check_reset_state("reset");

    for (int d = 1; d <= 8; d++) wr(4'(d));
    check("fill_data", DATA, 32'h87654321);
    check("fill_ovld", {31'd0, out_valid}, 32'd1);
    check("fill_rdy",  {31'd0, in_ready}, 32'd0);
    check("fill_num",  {29'd0, NUM}, 32'd0);

    in_valid = 1'b1; in_digit = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_hold", DATA, 32'h87654321);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_reset_state("consume");

    wr(4'hA); wr(4'hB); wr(4'hC);
    check("abc_data", DATA, 32'h00000CBA);
    check("abc_num",  {29'd0, NUM}, 32'd3);
    clear = 1'b1; in_valid = 1'b1; in_digit = 4'hD;
    step();
    clear = 1'b0; in_valid = 1'b0;
    check_reset_state("clear");

    for (int d = 1; d <= 5; d++) wr(4'(d));
    check("part_data", DATA, 32'h00054321);
    check("part_num",  {29'd0, NUM}, 32'd5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_reset_state("midreset");
    wr(4'h9);
    check("after_rst_data", DATA, 32'h00000009);
    check("after_rst_num",  {29'd0, NUM}, 32'd1);
    clear = 1'b1; step(); clear = 1'b0;

    out_ready = 1'b1;
    nwords = 0; bubbles = 0; cycles = 0; idx = 0;
    words[0] = '0; words[1] = '0;
    while (cycles < 40) begin
      cycles++;
      if (out_valid) begin
        if (nwords < 2) words[nwords] = DATA;
        nwords++;
      end
      if (!in_ready) bubbles++;
      if (nwords >= 2) break;
      rdy = in_ready;
      in_valid = (idx < 16);
      in_digit = 4'(idx);
      step();
      if (rdy && in_valid) idx++;
    end
    in_valid = 1'b0;
    check("stream_words",   32'(nwords), 32'd2);
    check("stream_word0",   words[0], 32'h76543210);
    check("stream_word1",   words[1], 32'hFEDCBA98);
    check("stream_bubbles", 32'(bubbles), 32'd2);
    check("stream_cycles",  32'(cycles), 32'd18);
    step();
    check("stream_drain_ovld", {31'd0, out_valid}, 32'd0);
    check("stream_drain_data", DATA, 32'h0);
    out_ready = 1'b0;

`ifdef NIBBLE_PACKER_BACKSPACE_EN
    wr(4'h1); wr(4'h2); wr(4'h3);
    bksp = 1'b1; step(); bksp = 1'b0;
    check("bksp_num",  {29'd0, NUM}, 32'd2);
    check("bksp_data", DATA, 32'h00000021);
    clear = 1'b1; step(); clear = 1'b0;
    bksp = 1'b1; step(); bksp = 1'b0;
    check("bksp0_num",  {29'd0, NUM}, 32'd0);
    check("bksp0_data", DATA, 32'h0);
    wr(4'h1); wr(4'h2);
    bksp = 1'b1; in_valid = 1'b1; in_digit = 4'h4;
    step();
    bksp = 1'b0; in_valid = 1'b0;
    check("bksp_acc_data", DATA, 32'h00000421);
    check("bksp_acc_num",  {29'd0, NUM}, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
